// File: rtl/hex_keypad_pkg.sv
// Shared constants for the 4x4 hex keypad scanner:
// scan FSM states, key code table and default timing.
package hex_keypad_pkg;

    localparam int DEF_SETTLE_CYCLES  = 256;
    localparam int DEF_DEBOUNCE_SCANS = 4;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE   = 2'd0;
    localparam scan_state_t ST_DRIVE  = 2'd1;
    localparam scan_state_t ST_SAMPLE = 2'd2;
    localparam scan_state_t ST_NEXT   = 2'd3;

    // Nibble i holds the code of map bit i (i = 4*row + col).
    localparam logic [63:0] CODE_TABLE = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code_of(input logic [3:0] idx);
        return CODE_TABLE[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_key_map_encoder.sv
// Combinational map-to-code encoder: code of the lowest set
// bit plus a flag telling whether exactly one bit is set.
module key_map_encoder (
    input  logic [15:0] map,
    output logic [3:0]  code,
    output logic        one_hot
);
    import hex_keypad_pkg::*;

    logic [3:0] idx;

    always_comb begin
        idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (map[i]) idx = 4'(i);
        end
        code    = key_code_of(idx);
        one_hot = (map != 16'h0) && ((map & (map - 16'd1)) == 16'h0);
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// Row-scanning 4x4 keypad controller with scan-level debounce,
// single-key press events and a four-code history word.
module hex_keypad_scanner #(
    parameter int SETTLE_CYCLES  = hex_keypad_pkg::DEF_SETTLE_CYCLES,
    parameter int DEBOUNCE_SCANS = hex_keypad_pkg::DEF_DEBOUNCE_SCANS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic [15:0] dataword
);
    import hex_keypad_pkg::*;

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE_SCANS);

    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [3:0]    pressed;
    scan_state_t   state;
    logic [1:0]    r;
    logic [CW-1:0] settle_cnt;
    logic [15:0]   scan_map;
    logic [15:0]   prev_map;
    logic [15:0]   deb_map;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nxt;
    logic          scan_done;
    logic          deb_upd;
    logic          deb_was_zero;
    logic [3:0]    enc_code;
    logic          enc_one_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    assign pressed = ~col_s2;

    always_comb begin
        row = 4'b1111;
        unique case (1'b1)
            (state == ST_DRIVE),
            (state == ST_SAMPLE): row = ~(4'b0001 << r);
            default:              row = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            r          <= 2'd0;
            settle_cnt <= '0;
            scan_map   <= 16'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    settle_cnt <= '0;
                    state      <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    scan_map[{r, 2'b00} +: 4] <= pressed;
                    state                     <= ST_NEXT;
                end
                ST_NEXT: begin
                    r     <= r + 2'd1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Row 3 was sampled last cycle, so scan_map is complete here.
    assign scan_done = (state == ST_NEXT) && (r == 2'd3);

    always_comb begin
        stable_nxt = '0;
        if (scan_map == prev_map) begin
            stable_nxt = (stable_cnt == STABLE_MAX) ?
                         stable_cnt : stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_map     <= 16'h0;
            stable_cnt   <= '0;
            deb_map      <= 16'h0;
            deb_upd      <= 1'b0;
            deb_was_zero <= 1'b0;
        end else begin
            deb_upd <= 1'b0;
            if (scan_done) begin
                prev_map   <= scan_map;
                stable_cnt <= stable_nxt;
                if (stable_nxt == STABLE_MAX) begin
                    deb_map      <= scan_map;
                    deb_upd      <= 1'b1;
                    deb_was_zero <= (deb_map == 16'h0);
                end
            end
        end
    end

    key_map_encoder u_enc (
        .map     (deb_map),
        .code    (enc_code),
        .one_hot (enc_one_hot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_down  <= 1'b0;
            dataword  <= 16'h0;
        end else begin
            key_valid <= 1'b0;
            key_down  <= (deb_map != 16'h0);
            if (deb_upd && deb_was_zero && enc_one_hot) begin
                key_valid <= 1'b1;
                key_code  <= enc_code;
                dataword  <= {dataword[11:0], enc_code};
            end
        end
    end

endmodule
